// File: rtl/ex38_pkg.sv
// Shared constants and the result record held by the ex38 register stage.
package ex38_pkg;

   localparam int unsigned DefaultWidth = 4;

   // Sized by the default width; the top keeps its WIDTH at this value.
   typedef struct packed {
      logic [DefaultWidth-1:0] sum;
      logic                    cout;
      logic                    ovf;
   } ex38_res_t;

endpackage

// File: rtl/ex38_full_adder_bit.sv
// Single-bit full adder cell used as one stage of the ex38 ripple chain.
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ cin;
   assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ex38.sv
// Ripple-carry adder with combinational outputs and an enabled, async-reset result register.
// Two's-complement overflow detection is built only when EX38_OVF_EN is defined.
module ex38
   import ex38_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             en,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [WIDTH-1:0] sum_q,
   output logic             cout_q,
   output logic             ovf,
   output logic             ovf_q
);

   logic [WIDTH:0] carry;
   ex38_res_t      res_d, res_q;

   assign carry[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder_bit u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .cin(carry[i]),
         .s  (sum[i]),
         .co (carry[i+1])
      );
   end

   assign cout = carry[WIDTH];

`ifdef EX38_OVF_EN
   // Signed overflow: carry into the sign bit disagrees with carry out of it.
   assign ovf   = carry[WIDTH-1] ^ carry[WIDTH];
   assign ovf_q = res_q.ovf;
`else
   assign ovf   = 1'b0;
   assign ovf_q = 1'b0;
`endif

   always_comb begin
      res_d = res_q;
      if (en) begin
         res_d.sum  = sum;
         res_d.cout = cout;
         res_d.ovf  = ovf;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q <= '0;
      end else begin
         res_q <= res_d;
      end
   end

   assign sum_q  = res_q.sum;
   assign cout_q = res_q.cout;

endmodule

// File: tb/tb_ex38.sv
// Self-checking bench for ex38: directed table, exhaustive sweep, random register traffic,
// and hand-written enable/reset sequences. Honours EX38_OVF_EN like the design.
module tb_ex38;

   localparam int W = 4;
`ifdef EX38_OVF_EN
   localparam bit OvfOn = 1'b1;
`else
   localparam bit OvfOn = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, en, cin;
   logic [W-1:0] a, b, sum, sum_q;
   logic         cout, cout_q, ovf, ovf_q;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference register state.
   int m_sum, m_cout, m_ovf;

   always #5 clk = ~clk;

   ex38 #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .en    (en),
      .sum   (sum),
      .cout  (cout),
      .sum_q (sum_q),
      .cout_q(cout_q),
      .ovf   (ovf),
      .ovf_q (ovf_q)
   );

   typedef struct {
      int    a, b, cin;
      int    s, co, ov;
      string name;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int to_signed(input int v);
      return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
   endfunction

   function automatic int ref_ovf(input int aa, input int bb, input int cc);
      int s;
      s = to_signed(aa) + to_signed(bb) + cc;
      return (OvfOn && (s > (1 << (W - 1)) - 1 || s < -(1 << (W - 1)))) ? 1 : 0;
   endfunction

   task automatic chk_comb(input string tag);
      int total;
      total = int'(a) + int'(b) + int'(cin);
      chk({tag, " sum"}, int'(sum), total % (1 << W));
      chk({tag, " cout"}, int'(cout), total >> W);
      chk({tag, " ovf"}, int'(ovf), ref_ovf(int'(a), int'(b), int'(cin)));
   endtask

   task automatic chk_reg(input string tag);
      chk({tag, " sum_q"}, int'(sum_q), m_sum);
      chk({tag, " cout_q"}, int'(cout_q), m_cout);
      chk({tag, " ovf_q"}, int'(ovf_q), m_ovf);
   endtask

   task automatic model_capture();
      int total;
      total  = int'(a) + int'(b) + int'(cin);
      m_sum  = total % (1 << W);
      m_cout = total >> W;
      m_ovf  = ref_ovf(int'(a), int'(b), int'(cin));
   endtask

   initial begin
      vec_t tbl[5];
      int   bad_sweep;

      tbl[0] = '{5, 3, 0, 8, 0, 1, "5+3+0"};
      tbl[1] = '{15, 1, 0, 0, 1, 0, "15+1+0"};
      tbl[2] = '{7, 8, 1, 0, 1, 0, "7+8+1"};
      tbl[3] = '{0, 0, 1, 1, 0, 0, "0+0+1"};
      tbl[4] = '{8, 8, 0, 0, 1, 1, "8+8+0"};

      rst = 1'b1; en = 1'b0; a = '0; b = '0; cin = 1'b0;
      m_sum = 0; m_cout = 0; m_ovf = 0;
      #1;
      chk_reg("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Directed vectors with hand-derived results.
      foreach (tbl[i]) begin
         a = tbl[i].a[W-1:0]; b = tbl[i].b[W-1:0]; cin = tbl[i].cin[0];
         #1;
         chk({tbl[i].name, " sum"}, int'(sum), tbl[i].s);
         chk({tbl[i].name, " cout"}, int'(cout), tbl[i].co);
         chk({tbl[i].name, " ovf"}, int'(ovf), OvfOn ? tbl[i].ov : 0);
      end

      // Exhaustive sweep counted as one comparison.
      bad_sweep = 0;
      for (int i = 0; i < 512; i++) begin
         a = i[W-1:0]; b = i[2*W-1:W]; cin = i[2*W];
         #1;
         if ({cout, sum} !== 5'(int'(a) + int'(b) + int'(cin))) bad_sweep++;
         if (ovf !== ref_ovf(int'(a), int'(b), int'(cin)) ? 1'b1 : 1'b0) bad_sweep++;
      end
      chk("sweep errors", bad_sweep, 0);

      // Capture then hold.
      @(negedge clk);
      en = 1'b1; a = 4'd9; b = 4'd9; cin = 1'b0;
      @(posedge clk); #1;
      chk("cap9 sum_q", int'(sum_q), 2);
      chk("cap9 cout_q", int'(cout_q), 1);
      chk("cap9 ovf_q", int'(ovf_q), OvfOn ? 1 : 0);
      model_capture();
      @(negedge clk);
      en = 1'b0; a = 4'd1; b = 4'd2; cin = 1'b1;
      @(posedge clk); #1;
      chk("hold sum_q", int'(sum_q), 2);
      chk("hold cout_q", int'(cout_q), 1);
      chk_comb("hold comb");

      // Random traffic against the model.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom); en = 1'($urandom);
         #1;
         chk_comb("rand comb");
         @(posedge clk);
         if (en) model_capture();
         #1;
         chk_reg("rand reg");
      end

      // Asynchronous reset mid-cycle, with priority over enable.
      @(negedge clk);
      en = 1'b1; a = 4'd6; b = 4'd7; cin = 1'b1;
      @(posedge clk); #1;
      model_capture();
      chk_reg("pre-rst");
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      m_sum = 0; m_cout = 0; m_ovf = 0;
      chk_reg("async rst");
      chk_comb("rst comb");
      @(posedge clk); #1;
      chk_reg("rst over en");
      @(negedge clk);
      rst = 1'b0; a = 4'd12; b = 4'd5; cin = 1'b0;
      @(posedge clk); #1;
      model_capture();
      chk("post-rst sum_q", int'(sum_q), 1);
      chk("post-rst cout_q", int'(cout_q), 1);
      chk_reg("post-rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
